// File: rtl/seg_pkg.sv
// Shared constants, state encoding and segment table for the seven-segment
// value formatter.
package seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_MINUS = 8'hBF;

  typedef enum logic [1:0] {IDLE, CONV, FORMAT} state_t;

  // Active-low {dp,g,f,e,d,c,b,a} patterns for hex digits 0..F
  localparam logic [7:0] HEX_SEG [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // Decimal digits needed for a data_w-bit unsigned magnitude
  function automatic int bd_digits(input int data_w);
    return (data_w * 301) / 1000 + 1;
  endfunction

endpackage

// File: rtl/nibble_to_seg.sv
// Combinational 4-bit to active-low seven-segment decoder (dp off).
module nibble_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] seg
);

  assign seg = HEX_SEG[nib];

endmodule

// File: rtl/seg_value_display.sv
// Seven-segment value formatter: hex or decimal (double-dabble) conversion with
// leading-zero blanking, floating minus sign and overflow indication.
module seg_value_display
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int DATA_W     = 16
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_value,
  input  logic                    in_signed,
  input  logic                    in_mode,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS*8-1:0] seg_n,
  output logic                    busy,
  output logic                    overflow
);

  localparam int HD    = (DATA_W + 3) / 4;
  localparam int BD    = bd_digits(DATA_W);
  localparam int ID    = (HD > BD) ? HD : BD;
  localparam int NA    = (ID > NUM_DIGITS) ? ID : NUM_DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  mag_q;
  logic [4*BD-1:0]    bcd_q;
  logic [4*BD-1:0]    bcd_adj;
  logic               neg_q, mode_q, blank_q;
  logic               accept;

  logic [4*NA-1:0]    bcd_ext, mag_ext;
  logic [3:0]         dig [NA];
  int                 msd;
  int                 sign_pos;
  logic               ovf_d;
  logic [7:0]         dec_seg [NUM_DIGITS];
  logic [NUM_DIGITS*8-1:0] seg_d;

  assign in_ready = (state_q == IDLE);
  assign busy     = ~in_ready;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = CONV;
      CONV:    if (!mode_q || cnt_q == CNT_W'(DATA_W - 1)) state_d = FORMAT;
      FORMAT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      seg_n    <= '1;
      overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept)
        cnt_q <= '0;
      else if (state_q == CONV)
        cnt_q <= cnt_q + CNT_W'(1);
      if (state_q == FORMAT) begin
        seg_n    <= seg_d;
        overflow <= ovf_d;
      end
    end
  end

  // Shift-add-3: correct every BCD digit >= 5 before shifting in the next bit
  always_comb begin
    for (int i = 0; i < BD; i++)
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? 4'(bcd_q[4*i +: 4] + 4'd3)
                                                     : bcd_q[4*i +: 4];
  end

  always_ff @(posedge Clk) begin
    if (accept) begin
      neg_q   <= in_signed & in_value[DATA_W-1];
      mag_q   <= (in_signed && in_value[DATA_W-1]) ? DATA_W'(-in_value) : in_value;
      mode_q  <= in_mode;
      blank_q <= blank_lz;
      bcd_q   <= '0;
    end else if (state_q == CONV && mode_q) begin
      mag_q <= mag_q << 1;
      bcd_q <= (4*BD)'({bcd_adj, mag_q[DATA_W-1]});
    end
  end

  // Format stage: pick digits, locate most significant nonzero, place sign
  assign bcd_ext = (4*NA)'(bcd_q);
  assign mag_ext = (4*NA)'(mag_q);

  always_comb begin
    for (int i = 0; i < NA; i++)
      dig[i] = mode_q ? bcd_ext[4*i +: 4] : mag_ext[4*i +: 4];
  end

  always_comb begin
    msd = 0;
    for (int i = 0; i < NA; i++)
      if (dig[i] != 4'd0) msd = i;
  end

  assign ovf_d    = (msd >= NUM_DIGITS) || (neg_q && (msd + 1 >= NUM_DIGITS));
  assign sign_pos = blank_q ? (msd + 1) : (NUM_DIGITS - 1);

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    nibble_to_seg u_dec (
      .nib (dig[k]),
      .seg (dec_seg[k])
    );
    assign seg_d[8*k +: 8] = ovf_d                       ? SEG_MINUS :
                             (neg_q && sign_pos == k)    ? SEG_MINUS :
                             (blank_q && k > msd)        ? SEG_BLANK :
                                                           dec_seg[k];
  end

endmodule

// File: tb/tb_seg_value_display.sv
// Bench for seg_value_display: a 6-digit and a 3-digit instance checked every
// cycle against an arithmetic display model and hand-computed patterns.
module tb_seg_value_display;

  logic        clk;
  logic        Reset_n;

  logic        a_valid, a_ready, a_signed, a_mode, a_blank, a_busy, a_ovf;
  logic [15:0] a_value;
  logic [47:0] a_seg;

  logic        b_valid, b_ready, b_signed, b_mode, b_blank, b_busy, b_ovf;
  logic [15:0] b_value;
  logic [23:0] b_seg;

  logic [47:0] ea_seg;
  logic        ea_ovf, ea_rdy;
  logic [23:0] eb_seg;
  logic        eb_ovf, eb_rdy;
  bit          chk_on;

  int n_cmp;
  int n_bad;

  seg_value_display #(.NUM_DIGITS(6), .DATA_W(16)) dut_a (
    .Clk(clk), .Reset_n(Reset_n), .in_valid(a_valid), .in_ready(a_ready),
    .in_value(a_value), .in_signed(a_signed), .in_mode(a_mode), .blank_lz(a_blank),
    .seg_n(a_seg), .busy(a_busy), .overflow(a_ovf)
  );

  seg_value_display #(.NUM_DIGITS(3), .DATA_W(16)) dut_b (
    .Clk(clk), .Reset_n(Reset_n), .in_valid(b_valid), .in_ready(b_ready),
    .in_value(b_value), .in_signed(b_signed), .in_mode(b_mode), .blank_lz(b_blank),
    .seg_n(b_seg), .busy(b_busy), .overflow(b_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Display model: digits by repeated division, then blanking/sign/overflow rules
  function automatic void model(input logic [15:0] v, input bit s, input bit m,
                                input bit b, input int nd,
                                output logic [63:0] seg, output bit ovf);
    logic [7:0] tbl [16];
    longint mag, tmp;
    bit     neg;
    int     d [12];
    int     base, msd, sp;
    logic [7:0] e;
    tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    neg  = s && v[15];
    mag  = neg ? (65536 - longint'(v)) : longint'(v);
    base = m ? 10 : 16;
    tmp  = mag;
    for (int i = 0; i < 12; i++) begin
      d[i] = int'(tmp % base);
      tmp  = tmp / base;
    end
    msd = 0;
    for (int i = 0; i < 12; i++)
      if (d[i] != 0) msd = i;
    ovf = (msd >= nd) || (neg && msd + 1 >= nd);
    sp  = b ? msd + 1 : nd - 1;
    seg = '0;
    for (int k = 0; k < nd; k++) begin
      if (ovf)                 e = 8'hBF;
      else if (neg && k == sp) e = 8'hBF;
      else if (b && k > msd)   e = 8'hFF;
      else                     e = tbl[d[k]];
      seg[8*k +: 8] = e;
    end
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      chk("a_seg",   64'(a_seg),  64'(ea_seg));
      chk("a_ovf",   64'(a_ovf),  64'(ea_ovf));
      chk("a_ready", 64'(a_ready), 64'(ea_rdy));
      chk("a_busy",  64'(a_busy),  64'(!ea_rdy));
      chk("b_seg",   64'(b_seg),  64'(eb_seg));
      chk("b_ovf",   64'(b_ovf),  64'(eb_ovf));
      chk("b_ready", 64'(b_ready), 64'(eb_rdy));
    end
  end

  task automatic send(input int sel, input logic [15:0] v, input bit s, input bit m,
                      input bit b, input logic [63:0] lit, input bit lit_ovf);
    logic [63:0] mseg;
    bit          movf;
    int          lat;
    int          nd;
    nd  = (sel == 0) ? 6 : 3;
    lat = m ? 17 : 2;
    model(v, s, m, b, nd, mseg, movf);
    chk("model_seg", mseg, lit);
    chk("model_ovf", 64'(movf), 64'(lit_ovf));
    @(negedge clk);
    if (sel == 0) begin
      a_valid = 1; a_value = v; a_signed = s; a_mode = m; a_blank = b;
    end else begin
      b_valid = 1; b_value = v; b_signed = s; b_mode = m; b_blank = b;
    end
    @(posedge clk);
    #1;
    if (sel == 0) begin
      ea_rdy = 0; a_valid = 0;
      a_value = ~v; a_signed = ~s; a_mode = ~m; a_blank = ~b;
    end else begin
      eb_rdy = 0; b_valid = 0;
      b_value = ~v; b_signed = ~s; b_mode = ~m; b_blank = ~b;
    end
    repeat (lat) @(posedge clk);
    #1;
    if (sel == 0) begin
      ea_rdy = 1; ea_seg = mseg[47:0]; ea_ovf = movf;
      chk("a_seg_lit", 64'(a_seg), lit);
      chk("a_ovf_lit", 64'(a_ovf), 64'(lit_ovf));
    end else begin
      eb_rdy = 1; eb_seg = mseg[23:0]; eb_ovf = movf;
      chk("b_seg_lit", 64'(b_seg), lit);
      chk("b_ovf_lit", 64'(b_ovf), 64'(lit_ovf));
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; chk_on = 0;
    a_valid = 0; a_value = '0; a_signed = 0; a_mode = 0; a_blank = 0;
    b_valid = 0; b_value = '0; b_signed = 0; b_mode = 0; b_blank = 0;
    ea_seg = '1; ea_ovf = 0; ea_rdy = 1;
    eb_seg = '1; eb_ovf = 0; eb_rdy = 1;
    Reset_n = 1;
    #2 Reset_n = 0;
    #1 chk_on = 1;
    repeat (3) @(negedge clk);
    chk("rst_seg",   64'(a_seg),  64'hFFFF_FFFF_FFFF);
    chk("rst_ready", 64'(a_ready), 64'd1);
    Reset_n = 1;
    repeat (2) @(posedge clk);

    send(0, 16'd1234, 0, 1, 1, 64'hFFFF_F9A4_B099, 0);
    send(0, 16'hFFD6, 1, 1, 1, 64'hFFFF_FFBF_99A4, 0);
    send(0, 16'hBEEF, 0, 0, 1, 64'hFFFF_8386_868E, 0);
    send(0, 16'h0000, 0, 1, 1, 64'hFFFF_FFFF_FFC0, 0);
    send(0, 16'h8000, 1, 1, 1, 64'hBFB0_A4F8_8280, 0);
    send(0, 16'd42,   0, 1, 0, 64'hC0C0_C0C0_99A4, 0);
    send(0, 16'hFFD6, 1, 1, 0, 64'hBFC0_C0C0_99A4, 0);
    send(0, 16'hFFFF, 1, 0, 1, 64'hFFFF_FFFF_BFF9, 0);
    send(0, 16'hFFFF, 0, 1, 1, 64'hFF82_9292_B092, 0);

    send(1, 16'd1000, 0, 1, 1, 64'hBF_BFBF, 1);
    send(1, 16'd999,  0, 1, 1, 64'h90_9090, 0);
    send(1, 16'hFF9C, 1, 1, 1, 64'hBF_BFBF, 1);
    send(1, 16'hFFF7, 1, 1, 1, 64'hFF_BF90, 0);
    send(1, 16'h0ABC, 0, 0, 1, 64'h88_83C6, 0);
    send(1, 16'h1ABC, 0, 0, 1, 64'hBF_BFBF, 1);

    // Abort a decimal conversion with reset five cycles after accept
    @(negedge clk);
    a_valid = 1; a_value = 16'd1234; a_signed = 0; a_mode = 1; a_blank = 1;
    @(posedge clk);
    #1 a_valid = 0; ea_rdy = 0;
    repeat (5) @(posedge clk);
    #2 Reset_n = 0;
    ea_seg = '1; ea_ovf = 0; ea_rdy = 1;
    eb_seg = '1; eb_ovf = 0; eb_rdy = 1;
    #1;
    chk("abort_seg",   64'(a_seg),  64'hFFFF_FFFF_FFFF);
    chk("abort_ready", 64'(a_ready), 64'd1);
    chk("abort_ovf",   64'(a_ovf),  64'd0);
    @(negedge clk);
    Reset_n = 1;
    repeat (25) @(posedge clk);
    @(negedge clk);
    chk_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
